// File: rtl/ledblink_sched.sv
// Round-robin LED blink scheduler: four requesters share one LED, each playing on/off/repeat patterns in ms.
// Optional LEDBLINK_SCHED_PREEMPT_EN lets requester 0 preempt an active pattern.
module ledblink_sched #(
  parameter logic [26:0] CLK_FREQ = 27'd125000000,
  parameter logic [16:0] T_1_MS   = 17'((32'(CLK_FREQ) + 32'd999) / 32'd1000)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  req_i,
  input  logic [39:0] on_ms_i,
  input  logic [39:0] off_ms_i,
  input  logic [15:0] reps_i,
  output logic [3:0]  gnt_o,
  output logic [3:0]  done_o,
  output logic        led_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ON, ST_OFF} state_t;

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d, done_q, done_d;
  logic        led_q, led_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d, idx_q, idx_d;
  logic [16:0] pre_q, pre_d;
  logic [9:0]  ms_q, ms_d, on_q, on_d, off_q, off_d;
  logic [3:0]  reps_q, reps_d;

  logic [9:0]  on_arr   [4];
  logic [9:0]  off_arr  [4];
  logic [3:0]  reps_arr [4];
  logic        win_found;
  logic [1:0]  win_idx;
  logic        tick;
  logic [9:0]  phase_len;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      on_arr[k]   = on_ms_i[10*k +: 10];
      off_arr[k]  = off_ms_i[10*k +: 10];
      reps_arr[k] = reps_i[4*k +: 4];
    end
  end

  // First requesting index at or after the pointer wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    for (int i = 0; i < 4; i++) begin
      if (!win_found && req_i[rr_ptr_q + 2'(i)]) begin
        win_found = 1'b1;
        win_idx   = rr_ptr_q + 2'(i);
      end
    end
  end

  assign tick      = (pre_q == T_1_MS - 17'd1);
  assign phase_len = (state_q == ST_ON) ? on_q : off_q;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = 4'b0000;
    led_d    = led_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    pre_d    = pre_q;
    ms_d     = ms_q;
    on_d     = on_q;
    off_d    = off_q;
    reps_d   = reps_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_LOAD;
          gnt_d    = 4'b0001 << win_idx;
          idx_d    = win_idx;
          rr_ptr_d = win_idx + 2'd1;
          pre_d    = '0;
          ms_d     = '0;
        end
      end
      ST_LOAD: begin
        on_d    = (on_arr[idx_q]   == 10'd0) ? 10'd1 : on_arr[idx_q];
        off_d   = (off_arr[idx_q]  == 10'd0) ? 10'd1 : off_arr[idx_q];
        reps_d  = (reps_arr[idx_q] == 4'd0)  ? 4'd1  : reps_arr[idx_q];
        state_d = ST_ON;
        led_d   = 1'b1;
        pre_d   = '0;
        ms_d    = '0;
      end
      default: begin
        if (!req_i[idx_q]) begin
          // Withdrawal: abandon silently, no completion pulse.
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          led_d   = 1'b0;
          pre_d   = '0;
          ms_d    = '0;
        end
`ifdef LEDBLINK_SCHED_PREEMPT_EN
        else if (req_i[0] && idx_q != 2'd0) begin
          state_d  = ST_LOAD;
          gnt_d    = 4'b0001;
          idx_d    = 2'd0;
          rr_ptr_d = 2'd1;
          led_d    = 1'b0;
          pre_d    = '0;
          ms_d     = '0;
        end
`endif
        else if (tick) begin
          pre_d = '0;
          if (ms_q == phase_len - 10'd1) begin
            ms_d = '0;
            if (state_q == ST_ON) begin
              state_d = ST_OFF;
              led_d   = 1'b0;
            end else begin
              reps_d = reps_q - 4'd1;
              if (reps_q == 4'd1) begin
                state_d = ST_IDLE;
                done_d  = gnt_q;
                gnt_d   = 4'b0000;
              end else begin
                state_d = ST_ON;
                led_d   = 1'b1;
              end
            end
          end else begin
            ms_d = ms_q + 10'd1;
          end
        end else begin
          pre_d = pre_q + 17'd1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      led_q    <= 1'b0;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      pre_q    <= '0;
      ms_q     <= '0;
      on_q     <= '0;
      off_q    <= '0;
      reps_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      led_q    <= led_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      pre_q    <= pre_d;
      ms_q     <= ms_d;
      on_q     <= on_d;
      off_q    <= off_d;
      reps_q   <= reps_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign led_o  = led_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ledblink_sched.sv
// Directed bench for ledblink_sched at CLK_FREQ=10000 (10 cycles per ms); covers the
// default build and, when LEDBLINK_SCHED_PREEMPT_EN is defined, the preemption path.
module tb_ledblink_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [39:0] on_ms = '0;
  logic [39:0] off_ms = '0;
  logic [15:0] reps = '0;
  logic [3:0]  gnt, done;
  logic        led, busy;

  int n_checks = 0;
  int n_errors = 0;

  ledblink_sched #(.CLK_FREQ(27'd10000)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .on_ms_i(on_ms), .off_ms_i(off_ms),
    .reps_i(reps), .gnt_o(gnt), .done_o(done), .led_o(led), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for led to reach lvl; the final compare also catches timeouts.
  task automatic wait_led(input logic lvl, input string tag);
    int n = 0;
    while (led !== lvl && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(led), 32'(lvl));
  endtask

  // Counts consecutive samples, starting with the current one, where led==lvl and done is quiet.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (led === lvl && done === 4'b0000 && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;
  logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] prev_gnt, last_done;
  int k, done_seen;

  initial begin
    #2;
    check("reset_gnt", 32'(gnt), 0);
    check("reset_led", 32'(led), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic pattern on requester 0: 3 ms on, 2 ms off, 2 reps.
    on_ms = 40'd3; off_ms = 40'd2; reps = 16'd2; req = 4'b0001;
    @(negedge clk);
    check("s1_gnt_load", 32'(gnt), 32'h1);
    check("s1_busy_load", 32'(busy), 1);
    check("s1_led_load", 32'(led), 0);
    @(negedge clk);
    on_ms = 40'd7;  // latched values must be unaffected
    run_len(1'b1, n); check("s1_on1", n, 30);
    run_len(1'b0, n); check("s1_off1", n, 20);
    run_len(1'b1, n); check("s1_on2", n, 30);
    run_len(1'b0, n); check("s1_off2", n, 20);
    check("s1_done", 32'(done), 32'h1);
    check("s1_gnt_clr", 32'(gnt), 0);
    check("s1_busy_clr", 32'(busy), 0);
    req = 4'b0000;
    @(negedge clk);
    check("s1_done_1cyc", 32'(done), 0);

    // Zero fields behave as 1.
    reset_dut();
    on_ms = '0; off_ms = '0; reps = '0; req = 4'b0001;
    wait_led(1'b1, "s5_wait_on");
    run_len(1'b1, n); check("s5_on", n, 10);
    run_len(1'b0, n); check("s5_off", n, 10);
    check("s5_done", 32'(done), 32'h1);
    req = 4'b0000;

    // Round robin with all four requesting.
    reset_dut();
    on_ms = {4{10'd1}}; off_ms = {4{10'd1}}; reps = 16'h1111; req = 4'b1111;
    prev_gnt = '0; last_done = '0; k = 0;
    for (int c = 0; c < 400 && k < 5; c++) begin
      @(negedge clk);
      if (done != 4'b0000) last_done = done;
      if (gnt != 4'b0000 && gnt != prev_gnt) begin
        check($sformatf("s2_gnt%0d", k), 32'(gnt), 32'(exp_seq[k]));
        if (k > 0) check($sformatf("s2_done_before%0d", k), 32'(last_done), 32'(exp_seq[k-1]));
        last_done = '0;
        k++;
      end
      prev_gnt = gnt;
    end
    check("s2_grants_seen", k, 5);
    req = 4'b0000;

    // Withdrawal of requester 2 mid-ON.
    reset_dut();
    on_ms = 40'd5 << 20; off_ms = 40'd5 << 20; reps = 16'h0100; req = 4'b0100;
    wait_led(1'b1, "s3_wait_on");
    check("s3_gnt", 32'(gnt), 32'h4);
    repeat (15) @(negedge clk);
    check("s3_still_on", 32'(led), 1);
    req = 4'b0000;
    @(negedge clk);
    check("s3_busy", 32'(busy), 0);
    check("s3_led", 32'(led), 0);
    check("s3_gnt_clr", 32'(gnt), 0);
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (done != 4'b0000) done_seen++;
      @(negedge clk);
    end
    check("s3_no_done", done_seen, 0);

    // Reset mid-OFF, then pointer restarts at 0.
    reset_dut();
    on_ms = 40'd1 << 10; off_ms = 40'd3 << 10; reps = 16'h0010; req = 4'b0010;
    wait_led(1'b1, "s4_wait_on");
    wait_led(1'b0, "s4_wait_off");
    repeat (5) @(negedge clk);
    check("s4_busy_pre", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("s4_gnt", 32'(gnt), 0);
    check("s4_led", 32'(led), 0);
    check("s4_busy", 32'(busy), 0);
    check("s4_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0; req = 4'b0011;
    @(negedge clk);
    check("s4_regrant0", 32'(gnt), 32'h1);
    req = 4'b0000;

    // Requester 0 arriving while requester 3 blinks.
    reset_dut();
    on_ms = 40'd5 << 30; off_ms = 40'd5 << 30; reps = 16'h1000; req = 4'b1000;
    wait_led(1'b1, "s6_wait_on");
    repeat (3) @(negedge clk);
    req = 4'b1001;
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done[3]) done_seen++;
    end
`ifdef LEDBLINK_SCHED_PREEMPT_EN
    check("s6_preempt_gnt", 32'(gnt), 32'h1);
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (done[3]) done_seen++;
    end
    check("s6_no_done3", done_seen, 0);
`else
    check("s6_no_preempt_gnt", 32'(gnt), 32'h8);
    for (int c = 0; c < 200 && done == 4'b0000; c++) @(negedge clk);
    check("s6_done3", 32'(done), 32'h8);
    @(negedge clk);
    check("s6_next_gnt0", 32'(gnt), 32'h1);
`endif
    req = 4'b0000;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ledblink_sched.md
LEDBLINK_SCHED -- requirements
Module: ledblink_sched

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 125000000, meaning the clk_i frequency in Hz (27-bit unsigned).
REQ-002 The block SHALL have parameter T_1_MS, default ceil(CLK_FREQ/1000), meaning clk_i cycles per millisecond tick (17-bit unsigned).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_i, input, 4 bits: per-requester blink request, level held until done_o or withdrawal.
REQ-006 The block SHALL have port on_ms_i, input, 40 bits: 4 x 10-bit LED on time in ms, requester k at [10k+9:10k].
REQ-007 The block SHALL have port off_ms_i, input, 40 bits: 4 x 10-bit LED off time in ms, same packing.
REQ-008 The block SHALL have port reps_i, input, 16 bits: 4 x 4-bit blink count, requester k at [4k+3:4k].
REQ-009 The block SHALL have port gnt_o, output, 4 bits: registered one-hot grant, all-zero when idle.
REQ-010 The block SHALL have port done_o, output, 4 bits: one-cycle pulse on the requester whose pattern completed.
REQ-011 The block SHALL have port led_o, output, 1 bit: shared LED drive, 1 = lit.
REQ-012 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, ON, OFF; busy_o is decoded from state.
REQ-014 IDLE with any req_i bit high SHALL go to LOAD next edge, setting gnt_o to the round-robin winner.
REQ-015 Round-robin search SHALL start at index (last granted + 1) mod 4; the search starts at 0 after reset.
REQ-016 LOAD SHALL latch the winner's on_ms, off_ms and reps; a zero field is treated as 1; later input changes are ignored.
REQ-017 LOAD SHALL last exactly one cycle, then go to ON.
REQ-018 ON SHALL drive led_o=1 for exactly on_ms*T_1_MS cycles, then go to OFF.
REQ-019 OFF SHALL drive led_o=0 for exactly off_ms*T_1_MS cycles, then decrement the remaining repetitions.
REQ-020 At the end of OFF, if repetitions remain, the FSM SHALL go to ON; otherwise it SHALL go to IDLE.
REQ-021 On the OFF-to-IDLE transition, done_o for the granted index SHALL pulse high one cycle and gnt_o SHALL clear.
REQ-022 The ms prescaler SHALL clear on entry to each of LOAD, ON and OFF so phase lengths are exact.
REQ-023 The ms counter SHALL be 10 bits, count up and compare for equality, with no wrap within a phase.
REQ-024 If the granted req_i bit drops in ON or OFF, the FSM SHALL go to IDLE next edge with led_o=0 and gnt_o=0, and done_o SHALL NOT pulse.
REQ-025 A requester re-asserting req_i in the IDLE cycle after its done_o SHALL compete normally, with lowest round-robin priority.
REQ-026 gnt_o, done_o and led_o SHALL be registered outputs with no combinational path from req_i.

Reset
REQ-027 rst_i high SHALL immediately force state=IDLE, led_o=0, gnt_o=0, done_o=0, busy_o=0, counters=0 and the round-robin pointer to 0.
REQ-028 Reset asserted mid-pattern SHALL abort it with no done_o pulse; operation SHALL resume on the first rising clk_i edge after release.

Configuration
REQ-029 The design SHALL support the macro LEDBLINK_SCHED_PREEMPT_EN.
REQ-030 With LEDBLINK_SCHED_PREEMPT_EN defined, req_i[0] high while another requester is granted in ON or OFF SHALL abort that pattern next edge (led_o=0, no done_o) and enter LOAD granting requester 0.
REQ-031 Without LEDBLINK_SCHED_PREEMPT_EN, there SHALL be no preemption; requester 0 waits for IDLE like the others.

Verification (CLK_FREQ=10000 so T_1_MS=10)
REQ-032 Scenario: req_i=0001, on=3, off=2, reps=2 -> led_o high 30 cycles, low 20, high 30, low 20; done_o=0001 for 1 cycle; gnt_o=0000.
REQ-033 Scenario: req_i=1111 held -> gnt_o sequence 0001, 0010, 0100, 1000, 0001; each grant is preceded by done_o of the prior requester.
REQ-034 Scenario: req_i[2] dropped 15 cycles into ON -> next edge state=IDLE, led_o=0, done_o stays 0000.
REQ-035 Scenario: on=0, off=0, reps=0 -> exactly one blink with led_o high 10 cycles, low 10, then done_o pulse.
REQ-036 Scenario: rst_i pulsed mid-OFF -> all outputs 0 without a clock edge; a new request after release grants index 0 first.
REQ-037 Scenario: with LEDBLINK_SCHED_PREEMPT_EN, req_i[3] active and req_i[0] raised in ON -> gnt_o changes 1000 to 0001 within 2 cycles and done_o[3] never pulses.
